merge_two_ins: RTL
==================

MERGE_TWO_INS -- requirements
Module: merge_two_ins

Interface
REQ-001 Parameter: data_width, default 256, width of each data beat.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in0_data  input  data_width  beat from source 0.
REQ-005 in0_valid  input  1  source 0 beat present.
REQ-006 in0_last  input  1  beat is final beat of source 0 burst.
REQ-007 in0_ready  output  1  source 0 beat accepted this cycle when high together with in0_valid.
REQ-008 in1_data, in1_valid, in1_last, in1_ready: same as REQ-004 to REQ-007, for source 1.
REQ-009 out_data  output  data_width  merged beat.
REQ-010 out_valid  output  1  out_data/out_last/out_src hold a beat.
REQ-011 out_last  output  1  copy of accepted in*_last.
REQ-012 out_src  output  1  0 = beat from source 0, 1 = beat from source 1.
REQ-013 out_ready  input  1  sink accepts the beat when high together with out_valid.
REQ-014 busy  output  1  high in LOCK0 or LOCK1.

Function
REQ-015 Output stage: a single register; load_en = !out_valid || out_ready.
REQ-016 Transfer: a beat is accepted when inX_valid && inX_ready. It appears on the outputs the next cycle, giving 1-cycle latency. Full throughput of 1 beat/cycle is sustained while out_ready = 1.
REQ-017 inX_ready = load_en && grant_X. grant_X is combinational from the state, the valids, and last_grant. At most one of in0_ready/in1_ready is high in any cycle.
REQ-018 States: IDLE, LOCK0, LOCK1.
REQ-019 IDLE, grant rules:
- only one source valid: that source is granted.
- both sources valid: the source != last_grant is granted (round-robin).
- neither source valid: no grant, state stays IDLE.
REQ-020 IDLE, on an accepted beat from source X:
- last_grant <= X.
- inX_last = 0: next state is LOCKX.
- inX_last = 1: state stays IDLE.
REQ-021 LOCKX: only source X is granted, even if the other source is valid and X is not. An accepted beat with inX_last = 1 returns the state to IDLE; otherwise the state stays LOCKX.
REQ-022 Bursts are never interleaved. All beats between a source's first beat and its last-flagged beat leave consecutively from that source, in order.
REQ-023 Back-pressure: while out_valid && !out_ready, the following hold stable:
- out_data, out_last, out_src, out_valid.
- both in*_ready = 0.
- state and last_grant.
REQ-024 Simultaneous output drain and new accept in the same cycle: the register loads the new beat and out_valid stays 1 with no bubble.
REQ-025 Output drains and no beat is accepted: out_valid <= 0 next cycle. out_data, out_last and out_src hold their previous values.
REQ-026 The block does not modify or reorder data bits. out_data equals the accepted in*_data exactly.
REQ-027 A single-beat burst (valid with last = 1 in IDLE) never enters LOCK state.

Reset
REQ-028 While rst = 1 at a clock edge, the registers take these values:
- out_valid = 0, out_data = 0, out_last = 0, out_src = 0.
- state = IDLE, busy = 0.
- last_grant = 1, so source 0 wins the first tie.
REQ-029 While rst = 1, in0_ready = in1_ready = 0.
REQ-030 Reset asserted mid-burst or with a held output beat: the lock is abandoned and the held beat is discarded. No partial beat appears after reset.

Verification
REQ-031 Tie after reset: in0 and in1 both valid with last = 1, out_ready = 1 -> beats leave with out_src order 0,1,0,1, one per cycle, first out_valid one cycle after the first accept.
REQ-032 Burst lock: in0 sends a 3-beat burst 0xA0,0xA1,0xA2 (last on 0xA2) while in1 is valid throughout -> output 0xA0,0xA1,0xA2 with src 0, then in1's beat with src 1; busy is 1 for the cycles after 0xA0 up to the acceptance of 0xA2.
REQ-033 Back-pressure: out_ready = 0 for 4 cycles with out_valid = 1 -> outputs stable, both readies 0; when out_ready = 1 is restored, the next beat follows with no loss or duplication.
REQ-034 Idle lock: in LOCK1 with in1_valid = 0 and in0_valid = 1 for 5 cycles -> in0_ready stays 0 and out_valid falls to 0; resumes when in1 delivers its last beat.
REQ-035 Reset mid-burst: rst pulsed for 1 cycle in LOCK0 while out_valid = 1 -> next cycle out_valid = 0, busy = 0, out_data = 0; a subsequent tie grants source 0.
REQ-036 Random stress: random valid/last/out_ready on both sources for 10000 cycles; a scoreboard checks per-source order, no burst interleave, and that the beats leaving equal the beats entering.

Source files
------------

// File: rtl/merge_two_ins.sv
// Two-source beat merger with burst locking and round-robin tie-break.
// A burst from one source (beats up to and including the one flagged last)
// is passed through without interleaving beats from the other source.
// The output is a single register stage with 1-cycle latency and full
// throughput while the sink is ready.
module merge_two_ins #(
  parameter int data_width = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] in0_data,
  input  logic                  in0_valid,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic [data_width-1:0] in1_data,
  input  logic                  in1_valid,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_src,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state;
  logic   last_grant;
  logic   grant0, grant1;
  logic   load_en;
  logic   acc0, acc1;

  // Output register may take a new beat when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection: locked source only, otherwise single requester or round-robin.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = in0_valid;
          grant1 = in1_valid;
        end
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: ;
    endcase
  end

  // Readies are forced low during reset so nothing is taken while it is held.
  assign in0_ready = !rst && load_en && grant0;
  assign in1_ready = !rst && load_en && grant1;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign busy      = (state != IDLE);

  // Output stage: load accepted beat, or go empty when drained with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (load_en) begin
      if (acc0) begin
        out_valid <= 1'b1;
        out_data  <= in0_data;
        out_last  <= in0_last;
        out_src   <= 1'b0;
      end else if (acc1) begin
        out_valid <= 1'b1;
        out_data  <= in1_data;
        out_last  <= in1_last;
        out_src   <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Lock FSM: stay on a source until its last-flagged beat is accepted.
  // last_grant resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else if (acc0) begin
      last_grant <= 1'b0;
      state      <= in0_last ? IDLE : LOCK0;
    end else if (acc1) begin
      last_grant <= 1'b1;
      state      <= in1_last ? IDLE : LOCK1;
    end
  end

endmodule
